// File: rtl/test_bin_sequencer_pkg.sv
// Shared types and helpers for the test bin sequencer.
//   state_e : FSM state encoding, also exported on the STATE debug port
//   BIN_*   : bit positions of the result bins
//   bin_sel : fixed-priority bin resolution from the per-test flags
package tbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LVL  = 2'd2,
    ST_EOT  = 2'd3
  } state_e;

  localparam int unsigned BIN_PASS = 0;
  localparam int unsigned BIN_LPBK = 1;
  localparam int unsigned BIN_CHK  = 2;
  localparam int unsigned BIN_LVL  = 3;
  localparam int unsigned BIN_TO   = 4;
  localparam int unsigned NBIN_MIN = 5;

  // Fail flags outrank the pass mark; result is one-hot or all zero.
  function automatic logic [NBIN_MIN-1:0] bin_sel(
    input logic f_lpbk,
    input logic f_chksum,
    input logic f_lvl,
    input logic f_timeout,
    input logic pass
  );
    logic [NBIN_MIN-1:0] r;
    r = '0;
    if (f_lpbk)         r[BIN_LPBK] = 1'b1;
    else if (f_chksum)  r[BIN_CHK]  = 1'b1;
    else if (f_lvl)     r[BIN_LVL]  = 1'b1;
    else if (f_timeout) r[BIN_TO]   = 1'b1;
    else if (pass)      r[BIN_PASS] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cc_maj_filter.sv
// Majority filter for the raw comparator input.
//   CLK, RST_N : clock, async active-low reset
//   CC_IN      : raw comparator bit
//   cc_f       : registered majority of the last FILT_LEN samples
module cc_maj_filter #(
  parameter int unsigned FILT_LEN = 7
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CC_IN,
  output logic cc_f
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [FILT_LEN-1:0] r_sh;
  logic                r_cc_f;
  logic [CW-1:0]       w_pop;

  // Popcount of the current window.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(FILT_LEN); i++) begin
      w_pop = w_pop + CW'(r_sh[i]);
    end
  end

  // Shift in the newest sample; decision lags the shift by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sh   <= '0;
      r_cc_f <= 1'b0;
    end else begin
      r_sh   <= {r_sh[FILT_LEN-2:0], CC_IN};
      r_cc_f <= (w_pop > CW'(FILT_LEN / 2));
    end
  end

  assign cc_f = r_cc_f;

endmodule

// File: rtl/test_bin_sequencer.sv
// Single-site test sequencer: SOT -> run phases -> level check -> timed EOT.
//   CLK, RST_N          : clock, async active-low reset
//   TST_STA             : start-of-test pulse from the handler
//   LPBK_DN, CHKSUM_DN  : phase done strobes, each arms a delayed flag sample
//   FINISH2K            : program finished, marks a pass candidate
//   TST_DN              : test done, starts the level-sample delay
//   CC_IN               : raw comparator input (majority filtered)
//   EOT                 : end-of-test, high for EOT_CYC cycles
//   BIN                 : one-hot bin result, held until next accepted SOT
//   V1ON, V2ON          : probe supply enables
//   BUSY                : high while not idle
//   SOT_ERR             : one-cycle pulse for a SOT received while busy
//   STATE               : debug state (0 IDLE, 1 RUN, 2 LVL, 3 EOT)
module test_bin_sequencer
  import tbs_pkg::*;
#(
  parameter int unsigned NBIN     = 10,
  parameter int unsigned FILT_LEN = 7,
  parameter int unsigned SMP_DLY  = 16,
  parameter int unsigned LVL_DLY  = 4088,
  parameter int unsigned TO_CYC   = 67108863,
  parameter int unsigned EOT_CYC  = 524288
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            TST_STA,
  input  logic            LPBK_DN,
  input  logic            CHKSUM_DN,
  input  logic            FINISH2K,
  input  logic            TST_DN,
  input  logic            CC_IN,
  output logic            EOT,
  output logic [NBIN-1:0] BIN,
  output logic            V1ON,
  output logic            V2ON,
  output logic            BUSY,
  output logic            SOT_ERR,
  output logic [1:0]      STATE
);

  localparam int unsigned SW = $clog2(SMP_DLY + 1);
  localparam int unsigned LW = $clog2(LVL_DLY + 1);
  localparam int unsigned TW = $clog2(TO_CYC + 1);
  localparam int unsigned EW = $clog2(EOT_CYC + 1);

  state_e          r_state;
  logic [SW-1:0]   r_cnt_a;
  logic [SW-1:0]   r_cnt_b;
  logic [LW-1:0]   r_cnt_lvl;
  logic [TW-1:0]   r_cnt_to;
  logic [EW-1:0]   r_cnt_eot;
  logic            r_f_lpbk;
  logic            r_f_chksum;
  logic            r_f_lvl;
  logic            r_f_timeout;
  logic            r_pass;
  logic            r_eot;
  logic [NBIN-1:0] r_bin;
  logic            r_v1on;
  logic            r_v2on;
  logic            r_busy;
  logic            r_sot_err;

  logic            w_cc_f;
  logic            w_in_run;
  logic            w_active;
  logic            w_a_fire;
  logic            w_b_fire;
  logic            w_lvl_fire;
  logic            w_to_fire;
  logic            w_enter_eot;
  logic            w_f_lpbk_n;
  logic            w_f_chksum_n;
  logic            w_f_lvl_n;
  logic            w_f_timeout_n;
  logic            w_pass_n;
  logic [NBIN-1:0] w_bin_n;

  cc_maj_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CC_IN (CC_IN),
    .cc_f  (w_cc_f)
  );

  // Sample/transition decisions and the flag values they produce this edge,
  // so the bin captured on EOT entry sees samples landing on the same edge.
  always_comb begin
    w_in_run   = (r_state == ST_RUN);
    w_active   = (r_state == ST_RUN) || (r_state == ST_LVL);
    // A strobe coinciding with the sample edge restarts instead of sampling.
    w_a_fire   = w_active && (r_cnt_a == SW'(SMP_DLY)) && !(w_in_run && LPBK_DN);
    w_b_fire   = w_active && (r_cnt_b == SW'(SMP_DLY)) && !(w_in_run && CHKSUM_DN);
    w_lvl_fire = (r_state == ST_LVL) && (r_cnt_lvl == LW'(LVL_DLY));
    // TST_DN wins over a simultaneous timeout.
    w_to_fire  = w_in_run && !TST_DN && (r_cnt_to == TW'(TO_CYC));
    w_enter_eot = w_lvl_fire || w_to_fire;

    w_f_lpbk_n    = w_a_fire   ? w_cc_f  : r_f_lpbk;
    w_f_chksum_n  = w_b_fire   ? w_cc_f  : r_f_chksum;
    w_f_lvl_n     = w_lvl_fire ? !w_cc_f : r_f_lvl;
    w_f_timeout_n = w_to_fire  ? 1'b1    : r_f_timeout;
    w_pass_n      = (w_in_run && FINISH2K) ? 1'b1 : r_pass;

    w_bin_n = NBIN'(bin_sel(w_f_lpbk_n, w_f_chksum_n, w_f_lvl_n,
                            w_f_timeout_n, w_pass_n));
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_cnt_lvl   <= '0;
      r_cnt_to    <= '0;
      r_cnt_eot   <= '0;
      r_f_lpbk    <= 1'b0;
      r_f_chksum  <= 1'b0;
      r_f_lvl     <= 1'b0;
      r_f_timeout <= 1'b0;
      r_pass      <= 1'b0;
      r_eot       <= 1'b0;
      r_bin       <= '0;
      r_v1on      <= 1'b0;
      r_v2on      <= 1'b0;
      r_busy      <= 1'b0;
      r_sot_err   <= 1'b0;
    end else begin
      r_sot_err <= TST_STA && (r_state != ST_IDLE);

      if (r_state == ST_IDLE) begin
        if (TST_STA) begin
          r_state     <= ST_RUN;
          r_busy      <= 1'b1;
          r_f_lpbk    <= 1'b0;
          r_f_chksum  <= 1'b0;
          r_f_lvl     <= 1'b0;
          r_f_timeout <= 1'b0;
          r_pass      <= 1'b0;
          r_cnt_a     <= '0;
          r_cnt_b     <= '0;
          r_cnt_lvl   <= '0;
          r_cnt_to    <= TW'(1);
          r_bin       <= '0;
          r_v1on      <= 1'b1;
          r_v2on      <= 1'b1;
        end
      end else begin
        r_f_lpbk    <= w_f_lpbk_n;
        r_f_chksum  <= w_f_chksum_n;
        r_f_lvl     <= w_f_lvl_n;
        r_f_timeout <= w_f_timeout_n;
        r_pass      <= w_pass_n;

        // Loopback sample counter: 0 = idle, counts 1..SMP_DLY.
        if (w_in_run && LPBK_DN)                       r_cnt_a <= SW'(1);
        else if (w_a_fire)                             r_cnt_a <= '0;
        else if (r_cnt_a != '0 && r_cnt_a != '1)       r_cnt_a <= r_cnt_a + SW'(1);

        // Checksum sample counter, same scheme.
        if (w_in_run && CHKSUM_DN)                     r_cnt_b <= SW'(1);
        else if (w_b_fire)                             r_cnt_b <= '0;
        else if (r_cnt_b != '0 && r_cnt_b != '1)       r_cnt_b <= r_cnt_b + SW'(1);

        if (w_b_fire)      r_v2on <= 1'b1;
        else if (w_a_fire) r_v2on <= 1'b0;

        case (r_state)
          ST_RUN: begin
            if (TST_DN) begin
              r_state   <= ST_LVL;
              r_cnt_lvl <= LW'(1);
            end else if (r_cnt_to != '1) begin
              r_cnt_to <= r_cnt_to + TW'(1);
            end
          end
          ST_LVL: begin
            if (r_cnt_lvl != '1) r_cnt_lvl <= r_cnt_lvl + LW'(1);
          end
          ST_EOT: begin
            if (r_cnt_eot == EW'(EOT_CYC)) begin
              r_state   <= ST_IDLE;
              r_eot     <= 1'b0;
              r_busy    <= 1'b0;
              r_cnt_eot <= '0;
            end else if (r_cnt_eot != '1) begin
              r_cnt_eot <= r_cnt_eot + EW'(1);
            end
          end
          default: ;
        endcase

        // EOT entry overrides any supply/counter update made above.
        if (w_enter_eot) begin
          r_state   <= ST_EOT;
          r_eot     <= 1'b1;
          r_cnt_eot <= EW'(1);
          r_bin     <= w_bin_n;
          r_v1on    <= 1'b0;
          r_v2on    <= 1'b0;
          r_cnt_a   <= '0;
          r_cnt_b   <= '0;
          r_cnt_lvl <= '0;
        end
      end
    end
  end

  assign EOT     = r_eot;
  assign BIN     = r_bin;
  assign V1ON    = r_v1on;
  assign V2ON    = r_v2on;
  assign BUSY    = r_busy;
  assign SOT_ERR = r_sot_err;
  assign STATE   = r_state;

endmodule

// File: tb/tb_test_bin_sequencer.sv
// Directed bench for test_bin_sequencer with small test timing parameters.
module tb_test_bin_sequencer;

  localparam int unsigned NBIN     = 10;
  localparam int unsigned FILT_LEN = 7;
  localparam int unsigned SMP_DLY  = 16;
  localparam int unsigned LVL_DLY  = 8;
  localparam int unsigned TO_CYC   = 1000;
  localparam int unsigned EOT_CYC  = 20;

  localparam int SIG_STA = 0;
  localparam int SIG_LPBK = 1;
  localparam int SIG_CHK = 2;
  localparam int SIG_FIN = 3;
  localparam int SIG_TDN = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tst_sta = 1'b0;
  logic            lpbk_dn = 1'b0;
  logic            chksum_dn = 1'b0;
  logic            finish2k = 1'b0;
  logic            tst_dn = 1'b0;
  logic            cc_in = 1'b0;
  logic            eot;
  logic [NBIN-1:0] bin;
  logic            v1on;
  logic            v2on;
  logic            busy;
  logic            sot_err;
  logic [1:0]      state;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   cc_mode = 0;
  logic cc_static = 1'b1;
  logic [6:0] cc_pat = 7'b0;

  always #5 clk = ~clk;

  test_bin_sequencer #(
    .NBIN     (NBIN),
    .FILT_LEN (FILT_LEN),
    .SMP_DLY  (SMP_DLY),
    .LVL_DLY  (LVL_DLY),
    .TO_CYC   (TO_CYC),
    .EOT_CYC  (EOT_CYC)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .TST_STA   (tst_sta),
    .LPBK_DN   (lpbk_dn),
    .CHKSUM_DN (chksum_dn),
    .FINISH2K  (finish2k),
    .TST_DN    (tst_dn),
    .CC_IN     (cc_in),
    .EOT       (eot),
    .BIN       (bin),
    .V1ON      (v1on),
    .V2ON      (v2on),
    .BUSY      (busy),
    .SOT_ERR   (sot_err),
    .STATE     (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to just after edge n relative to the last SOT edge.
  task automatic go_to(input int n);
    if (n > cyc) step(n - cyc);
    cyc = n;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      SIG_STA:  tst_sta   = v;
      SIG_LPBK: lpbk_dn   = v;
      SIG_CHK:  chksum_dn = v;
      SIG_FIN:  finish2k  = v;
      default:  tst_dn    = v;
    endcase
  endtask

  // Strobe sampled on edge 'at'.
  task automatic pulse(input int which, input int at);
    go_to(at - 1);
    drive(which, 1'b1);
    go_to(at);
    drive(which, 1'b0);
  endtask

  task automatic sot();
    tst_sta = 1'b1;
    step(1);
    tst_sta = 1'b0;
    cyc = 0;
  endtask

  // Comparator stimulus: static level or a period-7 pattern.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      cc_in = (cc_mode == 0) ? cc_static : cc_pat[ph];
      ph = (ph + 1) % 7;
    end
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Reset state
    step(3);
    chk("rst_eot", 32'(eot), 32'h0);
    chk("rst_bin", 32'(bin), 32'h0);
    chk("rst_v1", 32'(v1on), 32'h0);
    chk("rst_v2", 32'(v2on), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    rst_n = 1'b1;
    step(12);

    // 1. Pass
    sot();
    chk("p_state_run", 32'(state), 32'h1);
    chk("p_busy", 32'(busy), 32'h1);
    chk("p_v1", 32'(v1on), 32'h1);
    chk("p_v2", 32'(v2on), 32'h1);
    pulse(SIG_FIN, 50);
    pulse(SIG_TDN, 100);
    chk("p_state_lvl", 32'(state), 32'h2);
    go_to(107);
    chk("p_eot_pre", 32'(eot), 32'h0);
    go_to(108);
    chk("p_eot_rise", 32'(eot), 32'h1);
    chk("p_bin", 32'(bin), 32'h001);
    chk("p_v1_off", 32'(v1on), 32'h0);
    chk("p_state_eot", 32'(state), 32'h3);
    go_to(127);
    chk("p_eot_last", 32'(eot), 32'h1);
    go_to(128);
    chk("p_eot_fall", 32'(eot), 32'h0);
    chk("p_busy_off", 32'(busy), 32'h0);
    chk("p_bin_hold", 32'(bin), 32'h001);
    step(2);

    // 2. Loopback fail
    sot();
    chk("l_bin_clr", 32'(bin), 32'h0);
    pulse(SIG_LPBK, 30);
    go_to(45);
    chk("l_v2_pre", 32'(v2on), 32'h1);
    go_to(46);
    chk("l_v2_off", 32'(v2on), 32'h0);
    pulse(SIG_FIN, 50);
    go_to(59);
    cc_static = 1'b0;
    pulse(SIG_TDN, 100);
    go_to(108);
    chk("l_bin", 32'(bin), 32'h002);
    go_to(128);
    chk("l_idle", 32'(state), 32'h0);
    cc_static = 1'b1;
    step(12);

    // 3a. Timeout
    sot();
    go_to(999);
    chk("t_eot_pre", 32'(eot), 32'h0);
    go_to(1000);
    chk("t_eot_rise", 32'(eot), 32'h1);
    chk("t_bin", 32'(bin), 32'h010);
    go_to(1020);
    chk("t_idle", 32'(state), 32'h0);
    step(2);

    // 3b. TST_DN on the timeout edge
    sot();
    pulse(SIG_TDN, 1000);
    chk("t2_state_lvl", 32'(state), 32'h2);
    go_to(1008);
    chk("t2_state_eot", 32'(state), 32'h3);
    chk("t2_bin", 32'(bin), 32'h000);
    go_to(1028);
    step(2);

    // 4a. Filter: 3 of 7 high
    cc_pat = 7'b0011100;
    cc_mode = 1;
    step(12);
    sot();
    pulse(SIG_CHK, 20);
    go_to(36);
    chk("f3_v2", 32'(v2on), 32'h1);
    pulse(SIG_TDN, 50);
    go_to(58);
    chk("f3_bin", 32'(bin), 32'h008);
    go_to(78);

    // 4b. Filter: 4 of 7 high
    cc_pat = 7'b0111100;
    step(12);
    sot();
    pulse(SIG_CHK, 20);
    pulse(SIG_TDN, 50);
    go_to(58);
    chk("f4_bin", 32'(bin), 32'h004);
    go_to(78);
    cc_mode = 0;
    cc_static = 1'b1;
    step(12);

    // 5. SOT while running, repeated loopback strobe
    sot();
    go_to(9);
    chk("b_soterr_pre", 32'(sot_err), 32'h0);
    pulse(SIG_STA, 10);
    chk("b_soterr", 32'(sot_err), 32'h1);
    chk("b_state", 32'(state), 32'h1);
    go_to(11);
    chk("b_soterr_end", 32'(sot_err), 32'h0);
    pulse(SIG_LPBK, 20);
    pulse(SIG_LPBK, 30);
    go_to(36);
    chk("b_v2_36", 32'(v2on), 32'h1);
    go_to(45);
    chk("b_v2_45", 32'(v2on), 32'h1);
    go_to(46);
    chk("b_v2_46", 32'(v2on), 32'h0);
    pulse(SIG_TDN, 60);
    go_to(68);
    chk("b_bin", 32'(bin), 32'h002);
    go_to(88);
    step(2);

    // 6. Reset during EOT
    sot();
    pulse(SIG_FIN, 5);
    pulse(SIG_TDN, 20);
    go_to(28);
    chk("r_eot", 32'(eot), 32'h1);
    go_to(33);
    rst_n = 1'b0;
    #1;
    chk("r_eot_clr", 32'(eot), 32'h0);
    chk("r_bin_clr", 32'(bin), 32'h0);
    chk("r_v1_clr", 32'(v1on), 32'h0);
    chk("r_v2_clr", 32'(v2on), 32'h0);
    chk("r_state_clr", 32'(state), 32'h0);
    step(3);
    rst_n = 1'b1;
    step(12);
    sot();
    chk("r2_v1", 32'(v1on), 32'h1);
    chk("r2_bin", 32'(bin), 32'h0);
    pulse(SIG_FIN, 5);
    pulse(SIG_TDN, 20);
    go_to(28);
    chk("r2_eot", 32'(eot), 32'h1);
    chk("r2_bin_pass", 32'(bin), 32'h001);
    go_to(48);
    chk("r2_idle", 32'(state), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
